// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter in front of the MMU.
//   Merges the instruction-fetch port (word reads only) and the load/store
//   port (byte/half/word, signed/unsigned, read/write) onto one MMU request
//   interface. Each access runs IDLE -> ISSUE (one-cycle strobe) -> WAIT
//   (until mem_ready or watchdog expiry). Then the winning master gets a
//   one-cycle valid pulse.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   if_req/if_addr      fetch request and byte address
//   if_rdata/if_valid   fetch data and completion pulse
//   ls_req/ls_we/ls_signed/ls_width/ls_addr/ls_wdata
//                       load/store request fields
//   ls_rdata/ls_valid   load data and completion pulse
//   err                 pulses with a valid when the access timed out
//   read_enable, write_enable, mem_signed_read, mem_data_width, address,
//   data_in             registered MMU request signals
//   mmu_data_out, mem_ready   MMU response
//   busy                high while an access is in ISSUE or WAIT
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16  // legal range 2..255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic        ls_signed,
  input  logic [1:0]  ls_width,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic [31:0] ls_rdata,
  output logic        ls_valid,
  output logic        err,
  output logic        read_enable,
  output logic        write_enable,
  output logic        mem_signed_read,
  output logic [1:0]  mem_data_width,
  output logic [31:0] address,
  output logic [31:0] data_in,
  input  logic [31:0] mmu_data_out,
  input  logic        mem_ready,
  output logic        busy
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic        last_ls_reg, last_ls_next;   // 1: last completed grant was LS
  logic        gnt_ls_reg, gnt_ls_next;     // 1: access in flight belongs to LS
  logic        we_reg, we_next;

  logic [31:0] if_rdata_reg, if_rdata_next;
  logic        if_valid_reg, if_valid_next;
  logic [31:0] ls_rdata_reg, ls_rdata_next;
  logic        ls_valid_reg, ls_valid_next;
  logic        err_reg, err_next;
  logic        rd_en_reg, rd_en_next;
  logic        wr_en_reg, wr_en_next;
  logic        signed_reg, signed_next;
  logic [1:0]  width_reg, width_next;
  logic [31:0] address_reg, address_next;
  logic [31:0] data_in_reg, data_in_next;
  logic        busy_reg, busy_next;

  logic        pick_ls;
  logic        timed_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      last_ls_reg  <= 1'b0;
      gnt_ls_reg   <= 1'b0;
      we_reg       <= 1'b0;
      if_rdata_reg <= '0;
      if_valid_reg <= 1'b0;
      ls_rdata_reg <= '0;
      ls_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
      rd_en_reg    <= 1'b0;
      wr_en_reg    <= 1'b0;
      signed_reg   <= 1'b0;
      width_reg    <= '0;
      address_reg  <= '0;
      data_in_reg  <= '0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      last_ls_reg  <= last_ls_next;
      gnt_ls_reg   <= gnt_ls_next;
      we_reg       <= we_next;
      if_rdata_reg <= if_rdata_next;
      if_valid_reg <= if_valid_next;
      ls_rdata_reg <= ls_rdata_next;
      ls_valid_reg <= ls_valid_next;
      err_reg      <= err_next;
      rd_en_reg    <= rd_en_next;
      wr_en_reg    <= wr_en_next;
      signed_reg   <= signed_next;
      width_reg    <= width_next;
      address_reg  <= address_next;
      data_in_reg  <= data_in_next;
      busy_reg     <= busy_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    last_ls_next  = last_ls_reg;
    gnt_ls_next   = gnt_ls_reg;
    we_next       = we_reg;
    if_rdata_next = if_rdata_reg;
    if_valid_next = 1'b0;
    ls_rdata_next = ls_rdata_reg;
    ls_valid_next = 1'b0;
    err_next      = 1'b0;
    rd_en_next    = 1'b0;
    wr_en_next    = 1'b0;
    signed_next   = signed_reg;
    width_next    = width_reg;
    address_next  = address_reg;
    data_in_next  = data_in_reg;
    busy_next     = busy_reg;
    pick_ls       = 1'b0;
    timed_out     = 1'b0;

    case (state_reg)
      IDLE: begin
        // Arbitration also runs in the cycle a valid is pulsed, which is what
        // allows one access every three cycles under continuous demand.
        if (if_req || ls_req) begin
          // On contention the master that was not served last wins.
          pick_ls = ls_req && !(if_req && last_ls_reg);
          gnt_ls_next = pick_ls;
          if (pick_ls) begin
            we_next      = ls_we;
            address_next = ls_addr;
            width_next   = ls_width;
            signed_next  = ls_signed;
            data_in_next = ls_wdata;
          end else begin
            we_next      = 1'b0;
            address_next = if_addr;
            width_next   = 2'd3;
            signed_next  = 1'b0;
            data_in_next = '0;
          end
          // Strobes are registered here so they are high during ISSUE only.
          rd_en_next = !we_next;
          wr_en_next = we_next;
          busy_next  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT;
      end
      WAIT: begin
        if (mem_ready || (cnt_reg == CNT_LAST)) begin
          // mem_ready wins over the watchdog on the final wait cycle.
          timed_out    = !mem_ready;
          err_next     = timed_out;
          last_ls_next = gnt_ls_reg;
          busy_next    = 1'b0;
          state_next   = IDLE;
          if (gnt_ls_reg) begin
            ls_valid_next = 1'b1;
            if (timed_out) begin
              ls_rdata_next = '0;
            end else if (!we_reg) begin
              ls_rdata_next = mmu_data_out;
            end
          end else begin
            if_valid_next = 1'b1;
            if_rdata_next = timed_out ? '0 : mmu_data_out;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign if_rdata        = if_rdata_reg;
  assign if_valid        = if_valid_reg;
  assign ls_rdata        = ls_rdata_reg;
  assign ls_valid        = ls_valid_reg;
  assign err             = err_reg;
  assign read_enable     = rd_en_reg;
  assign write_enable    = wr_en_reg;
  assign mem_signed_read = signed_reg;
  assign mem_data_width  = width_reg;
  assign address         = address_reg;
  assign data_in         = data_in_reg;
  assign busy            = busy_reg;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter directly upstream of the memory management unit.
- Merges the instruction-fetch port (read-only word) and the load/store port (read/write, byte/half/word, signed/unsigned) onto the single MMU request interface.
- Sequences each access through the MMU's one-cycle request / mem_ready completion handshake and returns data with a one-cycle valid pulse to the winning master.
- Includes a bounded-wait watchdog and alternating-priority fairness.

Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT cycles before forced completion with error; legal range 2..255.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high until if_valid
- if_addr  in  32  fetch byte address
- if_rdata  out  32  fetch data; valid while if_valid=1, held otherwise
- if_valid  out  1  one-cycle fetch completion pulse
- ls_req  in  1  load/store request; held high until ls_valid
- ls_we  in  1  1=store, 0=load
- ls_signed  in  1  sign-extend load
- ls_width  in  2  0=byte, 1=half, 3=word (same encoding as mem_data_width)
- ls_addr  in  32  load/store byte address
- ls_wdata  in  32  store data, right-aligned
- ls_rdata  out  32  load data; valid while ls_valid=1
- ls_valid  out  1  one-cycle load/store completion pulse
- err  out  1  one-cycle pulse with if_valid or ls_valid when the access timed out
- read_enable  out  1  MMU read strobe
- write_enable  out  1  MMU write strobe
- mem_signed_read  out  1  to MMU
- mem_data_width  out  2  to MMU
- address  out  32  to MMU
- data_in  out  32  to MMU
- mmu_data_out  in  32  MMU read data
- mem_ready  in  1  MMU ready/completion
- busy  out  1  high in ISSUE and WAIT

Behaviour:
- Reset: all outputs 0, state IDLE, last_grant=IF, timeout counter 0. Reset asserted mid-access aborts it; no valid/err pulse follows.
- All MMU-side outputs and all master-side outputs are registered.
- IDLE:
  - Arbitration on sampled requests.
  - Only one request high: grant it.
  - Both high: grant the master that did not receive last_grant (first contention after reset therefore goes to LS).
  - Latch the granted request (addr, width, signed, wdata, we) into the MMU output registers and go to ISSUE.
  - Fetch grants always drive width=3, signed=0, write_enable=0.
  - No request: stay IDLE, strobes 0.
- ISSUE (exactly 1 cycle):
  - read_enable = !we, write_enable = we, both for this cycle only. Go to WAIT and clear the counter.
- WAIT:
  - Strobes 0; address, mem_data_width, mem_signed_read and data_in held stable.
  - mem_ready=1: capture mmu_data_out into the granted master's rdata, pulse its valid, update last_grant, return to IDLE.
  - Stores pulse ls_valid; ls_rdata is not updated on stores.
  - mem_ready=0: increment the counter.
  - Counter reaching TIMEOUT_CYCLES-1 with mem_ready still 0: pulse valid plus err, rdata=0, return to IDLE.
- Minimum latency: request sampled at edge N → ISSUE at N+1 → valid at N+3 (single-cycle MMU access).
- Back-to-back: a new grant is possible in the IDLE cycle after valid, so at most one access every 3 cycles.
- A request dropped before grant is withdrawn with no side effects. Request inputs changing after grant are ignored until completion.
- Never more than one access outstanding. if_valid and ls_valid are never high in the same cycle.
- Unaligned ls_addr is passed through unchanged; misalignment handling is the MMU's responsibility.

Test Plan:
- Single fetch: if_req=1, if_addr=0x00000004, MMU ready returns 0x00500093 → read_enable high exactly at cycle 1, if_valid+if_rdata=0x00500093 at cycle 3, err=0.
- Byte store: ls_req, we=1, width=0, addr=0x01000002, wdata=0xAB, mem_ready low 1 cycle → write_enable 1 cycle, mem_data_width=0, address held 0x01000002 through WAIT, ls_valid at cycle 4.
- Contention: if_req and ls_req both held continuously from reset → grants alternate LS, IF, LS, IF; valids every 3 cycles.
- Signed load: width=0, signed=1, addr=0x01000000, MMU returns 0xFFFFFF80 → mem_signed_read=1 during access, ls_rdata=0xFFFFFF80.
- Timeout: mem_ready tied 0 after issue → err+ls_valid after 16 WAIT cycles, ls_rdata=0, busy drops in the next cycle.
- Reset mid-WAIT: reset_n low during WAIT → all outputs 0 immediately, no valid pulse, next if_req serviced normally.
